io_tick_divider_bank: RTL and testbench
=======================================

// Module: io_tick_divider_bank
// PURPOSE
// - Parametrised bank of NUM_CH programmable tick dividers for IO peripherals (UART/SPI/timers).
// - Fully synchronous to sys_clk: sources are 1-cycle tick strobes, not clocks. Outputs are a tick
//   strobe plus a 50%-duty level per channel.
// - Adds per-channel enable, shadowed config with boundary-only update, and a global phase resync.
// - Sits on the IO config bus.
// PARAMETERS
// - NUM_CH   4   number of divider channels (1..8)
// - DIV_W   12   divisor width (1..12); config bits [11:DIV_W] ignored, read 0
// - ADDR_W   3   config address width; must satisfy 2**ADDR_W > NUM_CH
// PORTS
// - sys_clk              in   1          sole clock
// - sync_rst             in   1          reset, synchronous, active-high
// - clk_en               in   1          global advance enable
// - src_tick             in   3          source tick strobes (sources 1..3)
// - ConfigurationAddr    in   ADDR_W     0..NUM_CH-1 = channel reg; NUM_CH = global ctrl
// - ConfigWriteEnUpper   in   1          write ConfigInput[15:8]
// - ConfigWriteEnLower   in   1          write ConfigInput[7:0]
// - ConfigInput          in   16         write data
// - ConfigOutput         out  16         combinational readback
// - tick_out             out  NUM_CH     1-cycle pulse per divided period
// - level_out            out  NUM_CH     toggles on each tick_out (freq / 2(N+1))
// BEHAVIOUR
// - Channel reg: [DIV_W-1:0] N, [13:12] SRC, [14] EN, [15] reserved (read 0).
// - Sources: SRC=0 every cycle; SRC=1..3 -> src_tick[0..2].
// - Writes go to SHADOW. Readback returns SHADOW. Global reg (addr NUM_CH):
//   - write bit0=1 -> RESYNC pulse (self-clearing).
//   - read {16-NUM_CH zeros, EN bits of all channels}.
//   - unmapped addr: read 0, writes ignored.
// - Per channel: ACTIVE {N,SRC}, down-counter CNT[DIV_W-1:0].
// - Step = clk_en & EN_active & selected source tick. On step:
//   - CNT!=0: CNT--.
//   - CNT==0: CNT<=SHADOW.N; ACTIVE<=SHADOW; tick_out=1 next cycle; level_out toggles.
// - Period = N+1 source ticks. N=0 -> tick on every source tick.
// - Latency: step with CNT==0 at cycle t -> tick_out high at t+1 only (registered).
// - Shadow updates apply only at the period boundary (glitch-free retune). Exceptions:
//   - Disabled channel: ACTIVE tracks SHADOW each cycle; CNT=SHADOW.N; tick_out=0; level_out=0.
//   - EN 0->1 in SHADOW: counting starts next cycle from SHADOW.N.
//   - Write clearing EN: takes effect next cycle (immediate disable); level_out forced 0.
// - RESYNC (needs clk_en=1): all enabled channels load CNT=SHADOW.N, ACTIVE=SHADOW, level_out=0
//   in the same cycle. No tick emitted. Channels are then phase aligned.
// - Same-cycle collisions: a reload/RESYNC uses the pre-write SHADOW value. The new write lands in
//   SHADOW and applies at the next boundary.
// - clk_en=0: all state frozen, tick_out=0, writes still accepted into SHADOW.
// - sync_rst: SHADOW=ACTIVE=CNT=0, tick_out=0, level_out=0, ConfigOutput reads 0. Mid-period
//   reset aborts the count; no partial tick.
// CONFIGURATION
// - IO_TICK_CASCADE_EN defined: SRC=3 on channel k>0 selects tick_out[k-1]; channel 0 keeps
//   src_tick[2].
//   - Enables chained division (ch1 period = (N0+1)(N1+1) sys cycles at SRC0=0).
//   - Adds +1 cycle latency per stage.
// - Undefined: SRC=3 is src_tick[2] for every channel; no inter-channel paths.
// TESTING
// - Reset, write ch0=0x4003 (EN, SRC0, N=3) -> tick_out[0] every 4 cycles, first at cycle 5 after
//   write; level_out[0] period 8.
// - ch1 SRC1 N=1; pulse src_tick[0] every 3 cycles -> tick_out[1] every 6 cycles; no ticks
//   without src_tick.
// - ch0 running N=7; write N=2 mid-period -> current 8-cycle period completes, then 3-cycle
//   periods; readback 0x4002 immediately.
// - ch0 N=4, ch2 N=4 started 2 cycles apart; write addr NUM_CH data 0x0001 -> ticks coincident
//   thereafter, level_out both 0 after resync.
// - clk_en low 10 cycles mid-count -> no ticks, CNT held, period resumes exactly; sync_rst
//   mid-count -> all outputs 0 next cycle.
// - IO_TICK_CASCADE_EN: ch0 0x4001, ch1 0x7002 -> tick_out[1] every 6 cycles; without macro ch1
//   follows src_tick[2].

Source files
------------

// File: rtl/io_tick_divider_bank.sv
// Bank of NUM_CH programmable tick dividers (source tick -> divided tick strobe + 50% level).
// Latency: tick_out is registered, high the cycle after the terminal-count step.
// Backpressure: none; clk_en=0 freezes counters while config writes still land in the shadow.
// Optional build macro IO_TICK_CASCADE_EN: SRC=3 on channel k>0 follows tick_out[k-1].
module io_tick_divider_bank #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 12,
    parameter int ADDR_W = 3
) (
    input  logic                sys_clk,
    input  logic                sync_rst,
    input  logic                clk_en,
    input  logic [2:0]          src_tick,
    input  logic [ADDR_W-1:0]   ConfigurationAddr,
    input  logic                ConfigWriteEnUpper,
    input  logic                ConfigWriteEnLower,
    input  logic [15:0]         ConfigInput,
    output logic [15:0]         ConfigOutput,
    output logic [NUM_CH-1:0]   tick_out,
    output logic [NUM_CH-1:0]   level_out
);

    // Global control register sits directly above the channel registers.
    localparam logic [ADDR_W-1:0] GLB_ADDR = ADDR_W'(NUM_CH);

    // Per-channel configuration as held in the shadow register.
    typedef struct packed {
        logic             en;
        logic [1:0]       src;
        logic [DIV_W-1:0] n;
    } ch_cfg_t;

    logic              glb_sel;
    logic              resync;
    logic [DIV_W-1:0]  n_lane;
    logic [NUM_CH-1:0] src3;
    logic [NUM_CH-1:0] en_bits;
    logic [15:0]       rd_word [NUM_CH];

    // Bit 15 and any N bits at or above DIV_W are reserved and deliberately dropped.
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^ConfigInput;

    assign glb_sel = (ConfigurationAddr == GLB_ADDR);

    // RESYNC is a one-cycle strobe from the write itself; nothing stores it, so it self-clears.
    assign resync  = clk_en & ConfigWriteEnLower & glb_sel & ConfigInput[0];

    // Byte-lane enable per divisor bit: bits 7:0 belong to the lower lane, 11:8 to the upper.
    always_comb begin
        n_lane = '0;
        for (int b = 0; b < DIV_W; b++) begin
            n_lane[b] = (b < 8) ? ConfigWriteEnLower : ConfigWriteEnUpper;
        end
    end

    // Source 3 routing: either the shared src_tick[2] or the previous channel's tick strobe.
`ifdef IO_TICK_CASCADE_EN
    assign src3[0] = src_tick[2];
    for (genvar k = 1; k < NUM_CH; k++) begin : g_casc
        assign src3[k] = tick_out[k-1];
    end
`else
    assign src3 = {NUM_CH{src_tick[2]}};
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [ADDR_W-1:0] CH_ADDR = ADDR_W'(i);

        ch_cfg_t          shadow_q;
        ch_cfg_t          shadow_d;
        // Reloads always take N straight from the shadow, so only the source select is kept live.
        logic [1:0]       active_src_q;
        logic [DIV_W-1:0] cnt_q;
        logic             en_act_q;
        logic             tick_q;
        logic             level_q;
        logic             ch_sel;
        logic             en_eff;
        logic             src_hit;
        logic             step;
        logic [15:0]      rd_w;

        assign ch_sel = (ConfigurationAddr == CH_ADDR);

        // Merge byte-lane writes into the shadow copy.
        always_comb begin
            shadow_d = shadow_q;
            if (ch_sel) begin
                shadow_d.n = (shadow_q.n & ~n_lane) | (ConfigInput[DIV_W-1:0] & n_lane);
                if (ConfigWriteEnUpper) begin
                    shadow_d.src = ConfigInput[13:12];
                    shadow_d.en  = ConfigInput[14];
                end
            end
        end

        // Pick the tick source named by the live (not shadow) source select.
        always_comb begin
            case (active_src_q)
                2'd0:    src_hit = 1'b1;
                2'd1:    src_hit = src_tick[0];
                2'd2:    src_hit = src_tick[1];
                default: src_hit = src3[i];
            endcase
        end

        // Clearing EN in the shadow stops counting immediately; setting it waits for en_act_q,
        // which gives one cycle to preload CNT from the new N.
        assign en_eff = en_act_q & shadow_q.en;
        assign step   = clk_en & en_eff & src_hit;

        // Shadow capture, divider count, boundary reload and output strobes.
        always_ff @(posedge sys_clk) begin
            if (sync_rst) begin
                shadow_q     <= '0;
                active_src_q <= '0;
                cnt_q        <= '0;
                en_act_q     <= 1'b0;
                tick_q       <= 1'b0;
                level_q      <= 1'b0;
            end else begin
                shadow_q <= shadow_d;
                tick_q   <= 1'b0;
                if (clk_en) begin
                    if (!en_eff) begin
                        // Idle: follow the shadow so enabling starts from a clean period.
                        active_src_q <= shadow_q.src;
                        cnt_q        <= shadow_q.n;
                        level_q      <= 1'b0;
                        en_act_q     <= shadow_q.en;
                    end else if (resync) begin
                        // Phase alignment: restart the period without emitting a tick.
                        active_src_q <= shadow_q.src;
                        cnt_q        <= shadow_q.n;
                        level_q      <= 1'b0;
                    end else if (step) begin
                        if (cnt_q == '0) begin
                            // Period boundary: the only point a retune takes effect.
                            active_src_q <= shadow_q.src;
                            cnt_q        <= shadow_q.n;
                            tick_q       <= 1'b1;
                            level_q      <= ~level_q;
                        end else begin
                            cnt_q <= cnt_q - DIV_W'(1);
                        end
                    end
                end
            end
        end

        // Readback image of the shadow with reserved bits as zero.
        always_comb begin
            rd_w              = '0;
            rd_w[DIV_W-1:0]   = shadow_q.n;
            rd_w[13:12]       = shadow_q.src;
            rd_w[14]          = shadow_q.en;
        end

        assign rd_word[i]   = rd_w;
        assign en_bits[i]   = shadow_q.en;
        assign tick_out[i]  = tick_q;
        assign level_out[i] = level_q;
    end

    // Combinational readback: channel shadow, global enable summary, or zero when unmapped.
    always_comb begin
        ConfigOutput = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ConfigurationAddr == ADDR_W'(i)) begin
                ConfigOutput = rd_word[i];
            end
        end
        if (glb_sel) begin
            ConfigOutput[NUM_CH-1:0] = en_bits;
        end
    end

endmodule

// File: tb/tb_io_tick_divider_bank.sv
// Directed bench for io_tick_divider_bank: config table plus multi-cycle timing sequences.
// Latency: checks are taken #1 after each rising edge.
// Backpressure: n/a.
module tb_io_tick_divider_bank;

    logic        sys_clk = 1'b0;
    logic        sync_rst;
    logic        clk_en;
    logic [2:0]  src_tick;
    logic [2:0]  ConfigurationAddr;
    logic        ConfigWriteEnUpper;
    logic        ConfigWriteEnLower;
    logic [15:0] ConfigInput;
    logic [15:0] ConfigOutput;
    logic [3:0]  tick_out;
    logic [3:0]  level_out;

    int n_vec = 0;
    int n_err = 0;

    io_tick_divider_bank #(.NUM_CH(4), .DIV_W(12), .ADDR_W(3)) dut (
        .sys_clk            (sys_clk),
        .sync_rst           (sync_rst),
        .clk_en             (clk_en),
        .src_tick           (src_tick),
        .ConfigurationAddr  (ConfigurationAddr),
        .ConfigWriteEnUpper (ConfigWriteEnUpper),
        .ConfigWriteEnLower (ConfigWriteEnLower),
        .ConfigInput        (ConfigInput),
        .ConfigOutput       (ConfigOutput),
        .tick_out           (tick_out),
        .level_out          (level_out)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [2:0]  addr;
        logic        we_u;
        logic        we_l;
        logic [15:0] din;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t tbl [13];

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        ConfigurationAddr  = a;
        ConfigInput        = d;
        ConfigWriteEnUpper = 1'b1;
        ConfigWriteEnLower = 1'b1;
        cyc();
        ConfigWriteEnUpper = 1'b0;
        ConfigWriteEnLower = 1'b0;
    endtask

    task automatic do_reset();
        sync_rst           = 1'b1;
        clk_en             = 1'b1;
        src_tick           = '0;
        ConfigurationAddr  = '0;
        ConfigWriteEnUpper = 1'b0;
        ConfigWriteEnLower = 1'b0;
        ConfigInput        = '0;
        cyc();
        cyc();
        sync_rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[1]  = '{3'd0, 1'b1, 1'b1, 16'hFFFF, 16'h7FFF};
        tbl[2]  = '{3'd0, 1'b0, 1'b1, 16'h0012, 16'h7F12};
        tbl[3]  = '{3'd0, 1'b1, 1'b0, 16'h2155, 16'h2112};
        tbl[4]  = '{3'd1, 1'b1, 1'b1, 16'h1ABC, 16'h1ABC};
        tbl[5]  = '{3'd2, 1'b1, 1'b1, 16'h4005, 16'h4005};
        tbl[6]  = '{3'd3, 1'b1, 1'b1, 16'hC00F, 16'h400F};
        tbl[7]  = '{3'd4, 1'b0, 1'b0, 16'h0000, 16'h000C};
        tbl[8]  = '{3'd5, 1'b1, 1'b1, 16'hFFFF, 16'h0000};
        tbl[9]  = '{3'd1, 1'b0, 1'b0, 16'h0000, 16'h1ABC};
        tbl[10] = '{3'd4, 1'b1, 1'b1, 16'h0000, 16'h000C};
        tbl[11] = '{3'd0, 1'b1, 1'b0, 16'h4000, 16'h4012};
        tbl[12] = '{3'd4, 1'b0, 1'b0, 16'h0000, 16'h000D};

        // Reset state
        do_reset();
        chk("rst_tick", {12'h0, tick_out}, 16'h0);
        chk("rst_level", {12'h0, level_out}, 16'h0);
        chk("rst_rd0", ConfigOutput, 16'h0);

        // Config write / readback table
        for (int v = 0; v < 13; v++) begin
            ConfigurationAddr  = tbl[v].addr;
            ConfigWriteEnUpper = tbl[v].we_u;
            ConfigWriteEnLower = tbl[v].we_l;
            ConfigInput        = tbl[v].din;
            cyc();
            ConfigWriteEnUpper = 1'b0;
            ConfigWriteEnLower = 1'b0;
            chk($sformatf("cfg_rd[%0d]", v), ConfigOutput, tbl[v].exp_rd);
        end

        // ch0 N=3 from every cycle: first tick 5 after write, then every 4; level period 8
        do_reset();
        wr(3'd0, 16'h4003);
        for (int k = 1; k <= 21; k++) begin
            cyc();
            chk($sformatf("n3_tick k=%0d", k), {15'h0, tick_out[0]},
                {15'h0, (k >= 5 && (k - 5) % 4 == 0)});
            chk($sformatf("n3_level k=%0d", k), {15'h0, level_out[0]},
                {15'h0, (k >= 5 && ((k - 5) / 4) % 2 == 0)});
        end

        // ch1 SRC1 N=1: silent without source ticks, then every 6 cycles at 1-in-3 source rate
        do_reset();
        wr(3'd1, 16'h5001);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk("src1_idle", {12'h0, tick_out}, 16'h0);
        end
        for (int k = 0; k < 18; k++) begin
            src_tick[0] = (k % 3 == 0);
            cyc();
            chk($sformatf("src1_tick k=%0d", k), {15'h0, tick_out[1]}, {15'h0, (k % 6 == 3)});
        end
        src_tick = '0;

        // Retune mid-period: N=7 period finishes, then N=2 periods; readback immediate
        do_reset();
        wr(3'd0, 16'h4007);
        for (int k = 1; k <= 26; k++) begin
            if (k == 12) begin
                ConfigurationAddr  = 3'd0;
                ConfigInput        = 16'h4002;
                ConfigWriteEnUpper = 1'b1;
                ConfigWriteEnLower = 1'b1;
            end
            cyc();
            ConfigWriteEnUpper = 1'b0;
            ConfigWriteEnLower = 1'b0;
            if (k == 12) chk("retune_rd", ConfigOutput, 16'h4002);
            chk($sformatf("retune_tick k=%0d", k), {15'h0, tick_out[0]},
                {15'h0, (k == 9 || k == 17 || k == 20 || k == 23 || k == 26)});
        end

        // Global resync aligns ch0 and ch2 (started 2 cycles apart), levels cleared
        do_reset();
        wr(3'd0, 16'h4004);
        cyc();
        wr(3'd2, 16'h4004);
        for (int k = 0; k < 6; k++) cyc();
        chk("pre_resync_lvl0", {15'h0, level_out[0]}, 16'h1);
        chk("pre_resync_lvl2", {15'h0, level_out[2]}, 16'h1);
        ConfigurationAddr  = 3'd4;
        ConfigInput        = 16'h0001;
        ConfigWriteEnLower = 1'b1;
        cyc();
        ConfigWriteEnLower = 1'b0;
        chk("resync_lvl0", {15'h0, level_out[0]}, 16'h0);
        chk("resync_lvl2", {15'h0, level_out[2]}, 16'h0);
        chk("resync_notick", {12'h0, tick_out}, 16'h0);
        for (int k = 1; k <= 11; k++) begin
            cyc();
            chk($sformatf("resync_t0 k=%0d", k), {15'h0, tick_out[0]}, {15'h0, (k == 5 || k == 10)});
            chk($sformatf("resync_t2 k=%0d", k), {15'h0, tick_out[2]}, {15'h0, (k == 5 || k == 10)});
        end

        // clk_en low 10 cycles mid-count, then sync_rst mid-count
        do_reset();
        wr(3'd0, 16'h4003);
        for (int k = 1; k <= 25; k++) begin
            clk_en = !(k >= 7 && k <= 16);
            cyc();
            chk($sformatf("freeze_tick k=%0d", k), {15'h0, tick_out[0]},
                {15'h0, (k == 5 || k == 19 || k == 23)});
            if (k == 12) chk("freeze_level", {15'h0, level_out[0]}, 16'h1);
        end
        clk_en = 1'b1;
        chk("pre_rst_level", {15'h0, level_out[0]}, 16'h1);
        ConfigurationAddr = 3'd0;
        sync_rst = 1'b1;
        cyc();
        chk("midrst_tick", {12'h0, tick_out}, 16'h0);
        chk("midrst_level", {12'h0, level_out}, 16'h0);
        chk("midrst_rd", ConfigOutput, 16'h0);
        sync_rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("postrst_tick", {12'h0, tick_out}, 16'h0);
        end

        // Source 3 on ch1: cascade from ch0, or shared src_tick[2]
        do_reset();
        wr(3'd0, 16'h4001);
        wr(3'd1, 16'h7002);
`ifdef IO_TICK_CASCADE_EN
        for (int k = 2; k <= 22; k++) begin
            cyc();
            chk($sformatf("casc_t1 k=%0d", k), {15'h0, tick_out[1]},
                {15'h0, (k == 8 || k == 14 || k == 20)});
        end
`else
        for (int k = 2; k <= 11; k++) begin
            cyc();
            chk("src3_idle", {15'h0, tick_out[1]}, 16'h0);
        end
        src_tick[2] = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            cyc();
            chk($sformatf("src3_t1 k=%0d", k), {15'h0, tick_out[1]},
                {15'h0, (k == 2 || k == 5 || k == 8)});
        end
        src_tick = '0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
